// File: rtl/uart_tx_arb_pkg.sv
// uart_tx_arb_pkg: shared types and helpers for the UART TX arbiter.
package uart_tx_arb_pkg;
   typedef enum logic {IDLE, LOCK} state_t;
   localparam int BYTE_W = 8;
   function automatic int id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester streams, UART byte handshake and grant status.
interface uart_tx_arbiter_if #(parameter int NREQ = 4);
   import uart_tx_arb_pkg::*;
   localparam int IW = id_w(NREQ);
   logic [NREQ-1:0]        req_valid;
   logic [NREQ*BYTE_W-1:0] req_data;
   logic [NREQ-1:0]        req_last;
   logic [NREQ-1:0]        req_ready;
   logic                   tx_valid;
   logic [BYTE_W-1:0]      tx_data;
   logic                   tx_ready;
   logic                   gnt_valid;
   logic [IW-1:0]          gnt_id;
   logic                   timeout_pulse;
   modport master (
      output req_valid, req_data, req_last, tx_ready,
      input  req_ready, tx_valid, tx_data, gnt_valid, gnt_id, timeout_pulse
   );
   modport slave (
      input  req_valid, req_data, req_last, tx_ready,
      output req_ready, tx_valid, tx_data, gnt_valid, gnt_id, timeout_pulse
   );
endinterface

// File: rtl/uart_tx_arb_rr_pick.sv
// uart_tx_arb_rr_pick: first set request searching upward from ptr, with wrap-around.
module uart_tx_arb_rr_pick
   import uart_tx_arb_pkg::*;
#(
   parameter int NREQ = 4,
   localparam int IW = id_w(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic            hit,
   output logic [IW-1:0]   idx
);
   logic [IW-1:0] j;
   always_comb begin
      hit = |req;
      idx = '0;
      j   = '0;
      // walk offsets from farthest to nearest so the nearest hit wins
      for (int k = NREQ - 1; k >= 0; k--) begin
         j = IW'((int'(ptr) + k) % NREQ);
         idx = req[j] ? j : idx;
      end
   end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, message-locked arbiter in front of one UART TX byte engine.
// Optional grant revocation on mid-message idle is built when UART_TX_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter
   import uart_tx_arb_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 1024
) (
   input logic              clk,
   input logic              rst,
   uart_tx_arbiter_if.slave bus
);
   localparam int IW = id_w(NREQ);
   state_t        state;
   logic [IW-1:0] rr_ptr, gnt_id, pick, ptr_nxt;
   logic          hit, lock, cur_valid, fin, expire;
   assign lock      = state == LOCK;
   assign cur_valid = bus.req_valid[gnt_id];
   assign fin       = lock && cur_valid && bus.tx_ready && bus.req_last[gnt_id];
   assign ptr_nxt   = (gnt_id == IW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
   uart_tx_arb_rr_pick #(.NREQ(NREQ)) u_pick (
      .req (bus.req_valid),
      .ptr (rr_ptr),
      .hit (hit),
      .idx (pick)
   );
   assign bus.tx_valid  = lock && cur_valid;
   assign bus.tx_data   = lock ? bus.req_data[gnt_id*BYTE_W +: BYTE_W] : '0;
   assign bus.req_ready = (lock && bus.tx_ready) ? NREQ'(1) << gnt_id : '0;
   assign bus.gnt_valid = lock;
   assign bus.gnt_id    = lock ? gnt_id : '0;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         rr_ptr <= '0;
         gnt_id <= '0;
      end else if (!lock) begin
         state  <= hit ? LOCK : IDLE;
         gnt_id <= hit ? pick : gnt_id;
      end else if (fin || expire) begin
         state  <= IDLE;
         rr_ptr <= ptr_nxt;
      end
   end
`ifdef UART_TX_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] idle_cnt;
   logic          tp;
   assign expire = lock && !cur_valid && idle_cnt == CW'(TIMEOUT - 1);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idle_cnt <= '0;
         tp       <= 1'b0;
      end else begin
         idle_cnt <= (lock && !cur_valid && !expire) ? idle_cnt + 1'b1 : '0;
         tp       <= expire;
      end
   end
   assign bus.timeout_pulse = tp;
`else
   assign expire            = 1'b0;
   assign bus.timeout_pulse = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized scoreboard bench for uart_tx_arbiter against a message-level model.
module tb_uart_tx_arbiter;
   localparam int N = 4;
`ifdef UART_TX_ARB_TIMEOUT_EN
   localparam int TO = 16;
`else
   localparam int TO = 1024;
`endif
   logic clk = 1'b0;
   logic rst = 1'b1;
   uart_tx_arbiter_if #(.NREQ(N)) bus ();
   uart_tx_arbiter #(.NREQ(N), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   typedef struct {logic [7:0] d; logic l; int gap;} beat_t;
   typedef struct {logic gv; logic [1:0] gid; logic tv; logic [7:0] td; logic [N-1:0] rr; logic tp;} exp_t;
   beat_t src[N][$];
   logic [7:0] sent[N][$];
   logic [7:0] got[N][$];
   exp_t exp_q[$];
   exp_t me;
   int checks = 0, errors = 0;
   int owner = -1, ptr = 0, idle_cnt = 0, hs_id = -1;
   bit tp_pend = 0, tgl = 0;
   int rdy_pct = 100;
   bit pres[N];
   int gapc[N];
   logic [N-1:0] v, l;
   logic [N*8-1:0] d;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s got %0h want %0h at %0t", nm, act, req, $time);
      end
   endtask

   task automatic push_msg(input int r, input int len, input int gap_first, input int gap_rest);
      for (int i = 0; i < len; i++)
         src[r].push_back('{d: 8'($urandom_range(0, 255)), l: (i == len - 1), gap: (i == 0) ? gap_first : gap_rest});
   endtask

   // one cycle: retire last edge's handshake, drive inputs, predict this cycle's outputs
   task automatic step(input bit rst_now);
      exp_t e;
      int nxt;
      @(posedge clk);
      #1;
      rst = rst_now;
      if (hs_id >= 0) begin
         void'(src[hs_id].pop_front());
         pres[hs_id] = 0;
         hs_id = -1;
      end
      for (int r = 0; r < N; r++)
         if (!pres[r] && src[r].size() > 0) begin
            if (gapc[r] >= src[r][0].gap) begin
               pres[r] = 1;
               gapc[r] = 0;
            end else gapc[r]++;
         end
      for (int r = 0; r < N; r++) begin
         v[r] = pres[r];
         l[r] = pres[r] ? src[r][0].l : 1'($urandom_range(0, 1));
         d[8*r +: 8] = pres[r] ? src[r][0].d : 8'($urandom_range(0, 255));
      end
      bus.req_valid = v;
      bus.req_last  = l;
      bus.req_data  = d;
      bus.tx_ready  = tgl ? ~bus.tx_ready : ($urandom_range(0, 99) < rdy_pct);
      e = '{gv: 0, gid: 0, tv: 0, td: 0, rr: 0, tp: 0};
      if (rst_now) begin
         owner = -1; ptr = 0; idle_cnt = 0; tp_pend = 0;
      end else begin
         e.tp = tp_pend;
         tp_pend = 0;
         if (owner < 0) begin
            nxt = -1;
            for (int k = 0; k < N; k++)
               if (nxt < 0 && pres[(ptr + k) % N]) nxt = (ptr + k) % N;
            owner = nxt;
            idle_cnt = 0;
         end else begin
            e.gv  = 1;
            e.gid = 2'(owner);
            e.tv  = pres[owner];
            e.td  = d[8*owner +: 8];
            e.rr  = bus.tx_ready ? N'(1) << owner : '0;
            if (pres[owner] && bus.tx_ready) begin
               hs_id = owner;
               sent[owner].push_back(src[owner][0].d);
               if (src[owner][0].l) begin
                  ptr = (owner + 1) % N;
                  owner = -1;
               end
            end
`ifdef UART_TX_ARB_TIMEOUT_EN
            if (owner >= 0 && !pres[owner]) begin
               if (idle_cnt == TO - 1) begin
                  ptr = (owner + 1) % N;
                  owner = -1;
                  tp_pend = 1;
                  idle_cnt = 0;
               end else idle_cnt++;
            end else idle_cnt = 0;
`endif
         end
      end
      exp_q.push_back(e);
   endtask

   function automatic bit busy();
      for (int r = 0; r < N; r++) if (src[r].size() > 0) return 1;
      return 0;
   endfunction

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         me = exp_q.pop_front();
         chk("gnt_valid", 32'(bus.gnt_valid), 32'(me.gv));
         chk("gnt_id", 32'(bus.gnt_id), 32'(me.gid));
         chk("tx_valid", 32'(bus.tx_valid), 32'(me.tv));
         chk("tx_data", 32'(bus.tx_data), 32'(me.td));
         chk("req_ready", 32'(bus.req_ready), 32'(me.rr));
         chk("timeout_pulse", 32'(bus.timeout_pulse), 32'(me.tp));
      end
      if (!rst && bus.tx_valid && bus.tx_ready) got[bus.gnt_id].push_back(bus.tx_data);
   end

   initial begin
      int tot;
      bus.req_valid = '0;
      bus.req_last  = '0;
      bus.req_data  = '0;
      bus.tx_ready  = 1'b0;
      repeat (2) step(1);
      src[0].push_back('{d: 8'h41, l: 1'b0, gap: 0});
      src[0].push_back('{d: 8'h42, l: 1'b0, gap: 0});
      src[0].push_back('{d: 8'h43, l: 1'b1, gap: 0});
      repeat (8) step(0);
      step(1);
      for (int r = 0; r < N; r++) begin
         push_msg(r, 1, 0, 0);
         push_msg(r, 1, 0, 0);
      end
      repeat (20) step(0);
      push_msg(2, 5, 0, 0);
      tgl = 1;
      repeat (15) step(0);
      tgl = 0;
      push_msg(3, 2, 0, 0);
      push_msg(0, 1, 1, 0);
      repeat (10) step(0);
      push_msg(1, 2, 0, 20);
      push_msg(0, 1, 3, 0);
      push_msg(2, 1, 3, 0);
      repeat (50) step(0);
      rdy_pct = 80;
      for (int m = 0; m < 200; m++)
         push_msg($urandom_range(0, N - 1), $urandom_range(1, 4), $urandom_range(0, 2), $urandom_range(0, 2));
      for (int c = 0; c < 20000 && busy(); c++) step(0);
      repeat (4) step(0);
      rdy_pct = 100;
      push_msg(1, 6, 0, 0);
      push_msg(0, 1, 4, 0);
      repeat (3) step(0);
      step(1);
      for (int c = 0; c < 200 && busy(); c++) step(0);
      repeat (4) step(0);
      @(negedge clk);
      #1;
      tot = 0;
      for (int r = 0; r < N; r++) tot += src[r].size();
      chk("src_drained", 32'(tot), 32'd0);
      for (int r = 0; r < N; r++) begin
         chk("stream_len", 32'(got[r].size()), 32'(sent[r].size()));
         for (int i = 0; i < got[r].size() && i < sent[r].size(); i++)
            chk("stream_byte", 32'(got[r][i]), 32'(sent[r][i]));
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
